// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream clients, the shared UART transmitter and uart_tx_arbiter.
// The arbiter connects through the slave modport; clients and transmitter use master.
interface uart_tx_arbiter_if #(
    parameter int BYTE_WIDTH = 8,
    parameter int N_REQ      = 4
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*BYTE_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ready;
    logic                        tx_start;
    logic [BYTE_WIDTH-1:0]       tx_data;
    logic                        tx_done;
    logic                        busy;
    logic [3:0]                  grant_id;

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_data, busy, grant_id
    );

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_data, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing one UART byte transmitter among N_REQ requesters.
// Define UART_TX_ARB_HDR_EN to prefix every burst with a {4'hA, grant_id} header byte.
module uart_tx_arbiter #(
    parameter int BYTE_WIDTH = 8,
    parameter int N_REQ      = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDW = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4
`ifdef UART_TX_ARB_HDR_EN
        ,S_HDR  = 3'd5
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  last_q, last_d;
    logic                  tx_start_q;
    logic                  busy_q;
`ifdef UART_TX_ARB_HDR_EN
    logic                  hdr_q, hdr_d;
`endif

    logic [N_REQ-1:0]      valid_rot_s;
    logic [IDW-1:0]        pick_off_s;
    logic [IDW:0]          pick_sum_s;
    logic [IDW-1:0]        pick_s;
    logic [N_REQ-1:0]      grant_oh_s;
    logic                  sel_valid_s;
    logic                  sel_last_s;
    logic [BYTE_WIDTH-1:0] sel_data_s;
    logic [IDW-1:0]        rr_next_s;
    logic [N_REQ-1:0]      ready_s;

    // Rotate requests so rr_ptr lands on bit 0, then take the lowest set bit.
    always_comb begin
        valid_rot_s = N_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
        pick_off_s  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pick_off_s = valid_rot_s[k] ? IDW'(k) : pick_off_s;
        end
        pick_sum_s = {1'b0, rr_ptr_q} + {1'b0, pick_off_s};
        pick_s     = (pick_sum_s >= (IDW+1)'(N_REQ)) ?
                     IDW'(pick_sum_s - (IDW+1)'(N_REQ)) : pick_sum_s[IDW-1:0];
    end

    // Select the granted requester's handshake lane.
    always_comb begin
        grant_oh_s  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
        sel_valid_s = |(bus.req_valid & grant_oh_s);
        sel_last_s  = |(bus.req_last & grant_oh_s);
        sel_data_s  = BYTE_WIDTH'(bus.req_data >> (32'(grant_q) * 32'(BYTE_WIDTH)));
        rr_next_s   = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 4'd1;
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        ready_s   = '0;
`ifdef UART_TX_ARB_HDR_EN
        hdr_d     = hdr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid != '0) begin
                    grant_d = pick_s;
`ifdef UART_TX_ARB_HDR_EN
                    state_d = S_HDR;
`else
                    state_d = S_LOAD;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef UART_TX_ARB_HDR_EN
            S_HDR: begin
                tx_data_d = BYTE_WIDTH'({4'hA, grant_q});
                hdr_d     = 1'b1;
                state_d   = S_START;
            end
`endif
            S_LOAD: begin
                if (sel_valid_s) begin
                    ready_s   = grant_oh_s;
                    tx_data_d = sel_data_s;
                    last_d    = sel_last_s;
                    state_d   = S_START;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.tx_done) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            // Starting again before tx_done drops would clip the stop bit.
            S_DRAIN: begin
                if (!bus.tx_done) begin
`ifdef UART_TX_ARB_HDR_EN
                    hdr_d = 1'b0;
                    if (hdr_q) begin
                        state_d = S_LOAD;
                    end else if (!last_q) begin
`else
                    if (!last_q) begin
`endif
                        state_d = S_LOAD;
                    end else begin
                        state_d  = S_IDLE;
                        rr_ptr_d = rr_next_s;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointer, data and registered output flops.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_ARB_HDR_EN
            hdr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            tx_start_q <= (state_d == S_START);
            busy_q     <= (state_d != S_IDLE);
`ifdef UART_TX_ARB_HDR_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a burst vector table plus hand-timed latency,
// tx_done level-hold and mid-burst reset sequences against a simple transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int BW   = 8;
    localparam int NR   = 4;
    localparam int MAXB = 8;
`ifdef UART_TX_ARB_HDR_EN
    localparam logic [3:0] EXP_C1_READY = 4'b0000;
    localparam logic [7:0] EXP_C2_DATA  = 8'hA0;
    localparam int         EXP_FALLS    = 2;
`else
    localparam logic [3:0] EXP_C1_READY = 4'b0001;
    localparam logic [7:0] EXP_C2_DATA  = 8'h55;
    localparam int         EXP_FALLS    = 1;
`endif

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.BYTE_WIDTH(BW), .N_REQ(NR)) bus ();
    uart_tx_arbiter #(.BYTE_WIDTH(BW), .N_REQ(NR)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

    typedef struct {
        int         grp;
        int         src;
        logic [7:0] data;
        logic       last;
        int         dly;
    } vec_t;
    vec_t tbl[20];
    int   n_tbl = 0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] src_data [NR][MAXB];
    logic       src_last [NR][MAXB];
    int         src_n [NR];
    int         src_i [NR];
    int         src_dly [NR];
    logic       acc_seen [NR];

    logic [7:0] obs_data [32];
    logic [3:0] obs_grant [32];
    logic       obs_rdy [32];
    int         obs_cyc [32];
    int         obs_n = 0;
    int         fall_cyc [32];
    int         fall_n = 0;
    int         rdy_cnt [NR];
    int         onehot_err = 0;
    int         cyc = 0;
    logic       ready_flag = 1'b0;
    logic       prev_done = 1'b0;
    int         tx_cnt = 0;
    int         tx_wait_cfg = 2;
    int         tx_hold_cfg = 3;

    // Monitor DUT outputs and model the transmitter's tx_done level on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.tx_start === 1'b1 && obs_n < 32) begin
            obs_data[obs_n]  = bus.tx_data;
            obs_grant[obs_n] = bus.grant_id;
            obs_rdy[obs_n]   = ready_flag;
            obs_cyc[obs_n]   = cyc;
            obs_n            = obs_n + 1;
            ready_flag       = 1'b0;
        end
        if (bus.req_ready != '0) begin
            if (!$onehot(bus.req_ready)) onehot_err = onehot_err + 1;
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready[i]) begin
                    rdy_cnt[i]  = rdy_cnt[i] + 1;
                    acc_seen[i] = 1'b1;
                end
            end
            ready_flag = 1'b1;
        end
        if (!arst_n) tx_cnt = 0;
        else if (bus.tx_start === 1'b1) tx_cnt = 1;
        else if (tx_cnt > 0) tx_cnt = tx_cnt + 1;
        bus.tx_done = (tx_cnt > tx_wait_cfg) && (tx_cnt <= tx_wait_cfg + tx_hold_cfg);
        if (tx_cnt > tx_wait_cfg + tx_hold_cfg) tx_cnt = 0;
        if (prev_done && !bus.tx_done && fall_n < 32) begin
            fall_cyc[fall_n] = cyc;
            fall_n           = fall_n + 1;
        end
        prev_done = bus.tx_done;
    end

    // Requester model: present the head byte of each queue, advance just after acceptance.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc_seen[i]) begin
                    src_i[i]    = src_i[i] + 1;
                    acc_seen[i] = 1'b0;
                end
                if (src_dly[i] > 0) src_dly[i] = src_dly[i] - 1;
                if (src_dly[i] == 0 && src_i[i] < src_n[i]) begin
                    bus.req_valid[i]        = 1'b1;
                    bus.req_data[i*BW +: BW] = src_data[i][src_i[i]];
                    bus.req_last[i]         = src_last[i][src_i[i]];
                end else begin
                    bus.req_valid[i]        = 1'b0;
                    bus.req_data[i*BW +: BW] = '0;
                    bus.req_last[i]         = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int g, input int s, input logic [7:0] d, input logic l, input int dl);
        tbl[n_tbl] = '{grp: g, src: s, data: d, last: l, dly: dl};
        n_tbl      = n_tbl + 1;
    endtask

    task automatic clear_env();
        for (int i = 0; i < NR; i++) begin
            src_n[i]    = 0;
            src_i[i]    = 0;
            src_dly[i]  = 0;
            acc_seen[i] = 1'b0;
            rdy_cnt[i]  = 0;
        end
        obs_n      = 0;
        fall_n     = 0;
        ready_flag = 1'b0;
        onehot_err = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        arst_n = 1'b0;
        clear_env();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic run_group(input int g, input string tag);
        int   n_exp;
        int   j;
        int   bound;
        logic bstart;
        int   per_src [NR];
        clear_env();
        for (int s = 0; s < NR; s++) per_src[s] = 0;
        n_exp  = 0;
        bstart = 1'b1;
        for (int k = 0; k < n_tbl; k++) begin
            if (tbl[k].grp == g) begin
                if (src_n[tbl[k].src] == 0) src_dly[tbl[k].src] = tbl[k].dly;
                src_data[tbl[k].src][src_n[tbl[k].src]] = tbl[k].data;
                src_last[tbl[k].src][src_n[tbl[k].src]] = tbl[k].last;
                src_n[tbl[k].src]   = src_n[tbl[k].src] + 1;
                per_src[tbl[k].src] = per_src[tbl[k].src] + 1;
                n_exp = n_exp + 1;
`ifdef UART_TX_ARB_HDR_EN
                if (bstart) n_exp = n_exp + 1;
`endif
                bstart = tbl[k].last;
            end
        end
        bound = 0;
        while ((obs_n < n_exp || bus.busy !== 1'b0) && bound < 3000) begin
            @(negedge clk);
            bound = bound + 1;
        end
        @(negedge clk);
        check($sformatf("%s_starts", tag), obs_n, n_exp);
        j      = 0;
        bstart = 1'b1;
        for (int k = 0; k < n_tbl; k++) begin
            if (tbl[k].grp == g) begin
`ifdef UART_TX_ARB_HDR_EN
                if (bstart) begin
                    check($sformatf("%s_hdr%0d", tag, j), obs_data[j], {4'hA, 4'(tbl[k].src)});
                    check($sformatf("%s_hdrgrant%0d", tag, j), obs_grant[j], tbl[k].src);
                    check($sformatf("%s_hdrready%0d", tag, j), obs_rdy[j], 1'b0);
                    j = j + 1;
                end
`endif
                check($sformatf("%s_data%0d", tag, j), obs_data[j], tbl[k].data);
                check($sformatf("%s_grant%0d", tag, j), obs_grant[j], tbl[k].src);
                check($sformatf("%s_ready%0d", tag, j), obs_rdy[j], 1'b1);
                j      = j + 1;
                bstart = tbl[k].last;
            end
        end
        for (int s = 0; s < NR; s++) begin
            check($sformatf("%s_readycnt%0d", tag, s), rdy_cnt[s], per_src[s]);
        end
        check($sformatf("%s_onehot", tag), onehot_err, 0);
    endtask

    initial begin
        int b;
        // grp, src, data, last, start delay (first byte of a requester)
        add(1, 1, 8'h21, 1'b1, 0);  add(1, 0, 8'h20, 1'b1, 0);
        add(2, 0, 8'h10, 1'b1, 0);  add(2, 1, 8'h11, 1'b1, 0);
        add(2, 2, 8'h12, 1'b1, 0);  add(2, 3, 8'h13, 1'b1, 0);
        add(2, 0, 8'h14, 1'b1, 0);
        add(3, 2, 8'h01, 1'b0, 0);  add(3, 2, 8'h02, 1'b0, 0);
        add(3, 2, 8'h03, 1'b1, 0);  add(3, 1, 8'h11, 1'b1, 3);
        add(4, 2, 8'h31, 1'b0, 0);  add(4, 2, 8'h32, 1'b1, 0);
        add(5, 0, 8'h60, 1'b1, 0);  add(5, 3, 8'h63, 1'b1, 0);
        add(6, 3, 8'h7E, 1'b1, 0);

        clear_env();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_grant", bus.grant_id, 4'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Single byte with cycle-exact latency.
        src_data[0][0] = 8'h55;
        src_last[0][0] = 1'b1;
        src_n[0]       = 1;
        b = 0;
        while (bus.req_valid == '0 && b < 10) begin
            @(negedge clk);
            b = b + 1;
        end
        check("single_c0_busy", bus.busy, 1'b0);
        check("single_c0_ready", bus.req_ready, 4'b0000);
        @(negedge clk);
        check("single_c1_ready", bus.req_ready, EXP_C1_READY);
        check("single_c1_busy", bus.busy, 1'b1);
        @(negedge clk);
        check("single_c2_start", bus.tx_start, 1'b1);
        check("single_c2_data", bus.tx_data, EXP_C2_DATA);
        b = 0;
        while (bus.busy !== 1'b0 && b < 200) begin
            @(negedge clk);
            b = b + 1;
        end
        check("single_busy_end", bus.busy, 1'b0);
        check("single_falls", fall_n, EXP_FALLS);
        check("single_grant_end", bus.grant_id, 4'd0);
        repeat (2) @(negedge clk);

        run_group(1, "rrptr");
        apply_reset();
        run_group(2, "rr");
        run_group(3, "lock");

        tx_hold_cfg = 20;
        run_group(4, "hold");
        if (obs_n >= 2) begin
            check("hold_gap_fall", obs_cyc[obs_n-1] - fall_cyc[obs_n-2], 2);
            check("hold_gap_start", obs_cyc[obs_n-1] - obs_cyc[obs_n-2], 24);
        end else begin
            check("hold_gap_count", obs_n, 2);
        end
        tx_hold_cfg = 3;

        // Reset while the first byte of a burst is in flight.
        clear_env();
        src_data[1][0] = 8'h41;  src_last[1][0] = 1'b0;
        src_data[1][1] = 8'h42;  src_last[1][1] = 1'b1;
        src_n[1]       = 2;
        b = 0;
        while (obs_n < 1 && b < 100) begin
            @(negedge clk);
            b = b + 1;
        end
        @(negedge clk);
        check("midrst_pre_grant", bus.grant_id, 4'd1);
        check("midrst_pre_busy", bus.busy, 1'b1);
        #1 arst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_tx_start", bus.tx_start, 1'b0);
        check("midrst_tx_data", bus.tx_data, 8'h00);
        check("midrst_grant", bus.grant_id, 4'd0);
        check("midrst_ready", bus.req_ready, 4'b0000);
        clear_env();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        run_group(5, "postrst");
        run_group(6, "hdr");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
